// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between instruction fetch (ibus) and load/store (dbus).
// Optional slave-response watchdog (parameter TIMEOUT) is built when BUS_ARB_TIMEOUT_EN is defined.

module bus_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT      = 64
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_ibus_req,
    input  logic [31:0] i_ibus_addr,
    output logic [31:0] o_ibus_data,
    output logic        o_ibus_rsp,

    input  logic        i_dbus_req,
    input  logic        i_dbus_we,
    input  logic [31:0] i_dbus_addr,
    input  logic [31:0] i_dbus_wdata,
    input  logic [3:0]  i_dbus_be,
    output logic [31:0] o_dbus_data,
    output logic        o_dbus_rsp,

    output logic        o_s_req,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_be,
    input  logic [31:0] i_s_data,
    input  logic        i_s_rsp,

    output logic        o_err
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    state_t     state;
    logic [3:0] streak;
    logic       timeout_hit;
    logic       s_done;
    logic       d_wins;

    // D normally wins; once it has taken STREAK_LIMIT grants in a row, a waiting fetch goes next.
    assign d_wins = i_dbus_req && !(i_ibus_req && (streak == STREAK_LIMIT));
    assign s_done = i_s_rsp || timeout_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            streak  <= 4'd0;
            o_s_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state   <= GNT_D;
                        o_s_req <= 1'b1;
                        if (streak != STREAK_LIMIT) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (i_ibus_req) begin
                        state   <= GNT_I;
                        o_s_req <= 1'b1;
                        streak  <= 4'd0;
                    end else begin
                        streak  <= 4'd0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (s_done) begin
                        state   <= IDLE;
                        o_s_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_s_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent waiting on the slave; held at zero whenever no grant is open.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
        end else if ((state == IDLE) || s_done) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state != IDLE) && !i_s_rsp && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign o_err = timeout_hit;

    // A master that dropped req mid-grant no longer sees its response.
    always_comb begin
        o_s_we      = 1'b0;
        o_s_addr    = 32'h0;
        o_s_wdata   = 32'h0;
        o_s_be      = 4'h0;
        o_ibus_rsp  = 1'b0;
        o_ibus_data = 32'h0;
        o_dbus_rsp  = 1'b0;
        o_dbus_data = 32'h0;
        case (state)
            GNT_I: begin
                o_s_addr = i_ibus_addr;
                o_s_be   = 4'hF;
                if (i_ibus_req) begin
                    o_ibus_rsp = s_done;
                    if (i_s_rsp) begin
                        o_ibus_data = i_s_data;
                    end
                end
            end
            GNT_D: begin
                o_s_we    = i_dbus_we;
                o_s_addr  = i_dbus_addr;
                o_s_wdata = i_dbus_wdata;
                o_s_be    = i_dbus_be;
                if (i_dbus_req) begin
                    o_dbus_rsp = s_done;
                    if (i_s_rsp) begin
                        o_dbus_data = i_s_data;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
// Define BUS_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=8.

module tb_bus_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ibus_req = 1'b0;
    logic [31:0] ibus_addr = 32'h0;
    logic [31:0] ibus_data;
    logic        ibus_rsp;
    logic        dbus_req = 1'b0;
    logic        dbus_we = 1'b0;
    logic [31:0] dbus_addr = 32'h0;
    logic [31:0] dbus_wdata = 32'h0;
    logic [3:0]  dbus_be = 4'h0;
    logic [31:0] dbus_data;
    logic        dbus_rsp;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [31:0] s_data = 32'h0;
    logic        s_rsp = 1'b0;
    logic        err;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .MAX_D_STREAK(MAXS)
`ifdef BUS_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_ibus_req(ibus_req),
        .i_ibus_addr(ibus_addr),
        .o_ibus_data(ibus_data),
        .o_ibus_rsp(ibus_rsp),
        .i_dbus_req(dbus_req),
        .i_dbus_we(dbus_we),
        .i_dbus_addr(dbus_addr),
        .i_dbus_wdata(dbus_wdata),
        .i_dbus_be(dbus_be),
        .o_dbus_data(dbus_data),
        .o_dbus_rsp(dbus_rsp),
        .o_s_req(s_req),
        .o_s_we(s_we),
        .o_s_addr(s_addr),
        .o_s_wdata(s_wdata),
        .o_s_be(s_be),
        .i_s_data(s_data),
        .i_s_rsp(s_rsp),
        .o_err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ibus_req = 1'b1;
        dbus_req = 1'b1;
        s_rsp = 1'b1;
        s_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({s_req, s_we, s_addr, s_wdata, s_be} !== 70'h0)
            $display("[TB] FAIL reset_slave_bus: got %h, expected 0", {s_req, s_we, s_addr, s_wdata, s_be});
        else pass_cnt++;
        chk_cnt++;
        if ({ibus_rsp, ibus_data, dbus_rsp, dbus_data} !== 66'h0)
            $display("[TB] FAIL reset_master_rsp: got %h, expected 0", {ibus_rsp, ibus_data, dbus_rsp, dbus_data});
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b, expected 0", err);
        else pass_cnt++;
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        s_rsp = 1'b0;
        s_data = 32'h0;
        #2 rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk_cnt++;
        if (s_req !== 1'b0) $display("[TB] FAIL reset_idle_req: got %b, expected 0", s_req);
        else pass_cnt++;
    endtask

    task automatic test_i_read();
        tick();
        ibus_req = 1'b1;
        ibus_addr = 32'h100;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({s_req, s_we, s_addr, s_be} !== {1'b1, 1'b0, 32'h100, 4'hF})
            $display("[TB] FAIL i_read_bus: got %h, expected %h", {s_req, s_we, s_addr, s_be}, {1'b1, 1'b0, 32'h100, 4'hF});
        else pass_cnt++;
        chk_cnt++;
        if (ibus_rsp !== 1'b0) $display("[TB] FAIL i_read_early_rsp: got %b, expected 0", ibus_rsp);
        else pass_cnt++;
        tick();
        s_rsp = 1'b1;
        s_data = 32'h0000_0013;
        @(negedge clk);
        chk_cnt++;
        if ({ibus_rsp, ibus_data} !== {1'b1, 32'h13})
            $display("[TB] FAIL i_read_rsp: got %h, expected %h", {ibus_rsp, ibus_data}, {1'b1, 32'h13});
        else pass_cnt++;
        chk_cnt++;
        if ({dbus_rsp, dbus_data} !== 33'h0)
            $display("[TB] FAIL i_read_d_quiet: got %h, expected 0", {dbus_rsp, dbus_data});
        else pass_cnt++;
        tick();
        s_rsp = 1'b0;
        ibus_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({s_req, ibus_rsp} !== 2'b00) $display("[TB] FAIL i_read_release: got %b, expected 00", {s_req, ibus_rsp});
        else pass_cnt++;
    endtask

    task automatic test_d_write();
        int high = 0;
        tick();
        dbus_req = 1'b1;
        dbus_we = 1'b1;
        dbus_addr = 32'h2000;
        dbus_wdata = 32'hDEAD_BEEF;
        dbus_be = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            tick();
            s_rsp = (k == 4);
            s_data = 32'hCAFE_0000 + 32'(k);
            @(negedge clk);
            if (s_req === 1'b1) high++;
            chk_cnt++;
            if ({s_we, s_addr, s_wdata, s_be} !== {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011})
                $display("[TB] FAIL d_write_bus_%0d: got %h, expected %h", k, {s_we, s_addr, s_wdata, s_be},
                         {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011});
            else pass_cnt++;
            chk_cnt++;
            if ({dbus_rsp, ibus_rsp} !== {(k == 4), 1'b0})
                $display("[TB] FAIL d_write_rsp_%0d: got %b, expected %b", k, {dbus_rsp, ibus_rsp}, {(k == 4), 1'b0});
            else pass_cnt++;
        end
        tick();
        s_rsp = 1'b0;
        dbus_req = 1'b0;
        dbus_we = 1'b0;
        @(negedge clk);
        if (s_req === 1'b1) high++;
        chk_cnt++;
        if (high != 4) $display("[TB] FAIL d_write_req_cycles: got %0d, expected 4", high);
        else pass_cnt++;
    endtask

    task automatic test_streak();
        byte seq[$];
        string exp_seq = "DDDDIDDDDI";
        int slv_cnt = 0;
        bit i_new = 1'b0;
        bit d_new = 1'b0;
        tick();
        ibus_req = 1'b1;
        dbus_req = 1'b1;
        dbus_we = 1'b0;
        ibus_addr = $urandom;
        dbus_addr = $urandom;
        for (int cyc = 0; cyc < 200 && seq.size() < 10; cyc++) begin
            tick();
            if (i_new) ibus_addr = $urandom;
            if (d_new) dbus_addr = $urandom;
            i_new = 1'b0;
            d_new = 1'b0;
            slv_cnt = (s_req === 1'b1) ? slv_cnt + 1 : 0;
            s_rsp = (slv_cnt == 2);
            s_data = $urandom;
            @(negedge clk);
            chk_cnt++;
            if ((ibus_rsp === 1'b1) && (dbus_rsp === 1'b1))
                $display("[TB] FAIL streak_both_rsp: got 11, expected at most one");
            else pass_cnt++;
            if (dbus_rsp === 1'b1) begin
                seq.push_back("D");
                d_new = 1'b1;
                chk_cnt++;
                if ({dbus_data, s_addr} !== {s_data, dbus_addr})
                    $display("[TB] FAIL streak_d_route: got %h, expected %h", {dbus_data, s_addr}, {s_data, dbus_addr});
                else pass_cnt++;
            end else if (ibus_rsp === 1'b1) begin
                seq.push_back("I");
                i_new = 1'b1;
                chk_cnt++;
                if ({ibus_data, s_addr} !== {s_data, ibus_addr})
                    $display("[TB] FAIL streak_i_route: got %h, expected %h", {ibus_data, s_addr}, {s_data, ibus_addr});
                else pass_cnt++;
            end
        end
        tick();
        s_rsp = 1'b0;
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        chk_cnt++;
        if (seq.size() != 10) $display("[TB] FAIL streak_count: got %0d grants, expected 10", seq.size());
        else pass_cnt++;
        for (int i = 0; i < 10 && i < seq.size(); i++) begin
            chk_cnt++;
            if (seq[i] != exp_seq[i])
                $display("[TB] FAIL streak_grant_%0d: got %s, expected %s", i, string'(seq[i]), string'(exp_seq[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        tick();
        dbus_req = 1'b1;
        dbus_we = 1'b0;
        dbus_addr = 32'h3000;
        ibus_req = 1'b1;
        ibus_addr = 32'h400;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({s_req, s_addr} !== {1'b1, 32'h3000})
            $display("[TB] FAIL reset_mid_grant_d: got %h, expected %h", {s_req, s_addr}, {1'b1, 32'h3000});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        dbus_req = 1'b0;
        #1;
        chk_cnt++;
        if ({s_req, dbus_rsp} !== 2'b00) $display("[TB] FAIL reset_mid_async: got %b, expected 00", {s_req, dbus_rsp});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 32'h400})
            $display("[TB] FAIL reset_mid_grant_i: got %h, expected %h", {s_req, s_we, s_addr}, {1'b1, 1'b0, 32'h400});
        else pass_cnt++;
        tick();
        s_rsp = 1'b1;
        s_data = 32'h55;
        @(negedge clk);
        chk_cnt++;
        if ({ibus_rsp, ibus_data, dbus_rsp} !== {1'b1, 32'h55, 1'b0})
            $display("[TB] FAIL reset_mid_i_rsp: got %h, expected %h", {ibus_rsp, ibus_data, dbus_rsp}, {1'b1, 32'h55, 1'b0});
        else pass_cnt++;
        tick();
        s_rsp = 1'b0;
        ibus_req = 1'b0;
    endtask

    task automatic test_idle_rsp();
        tick();
        s_rsp = 1'b1;
        s_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_cnt++;
        if ({s_req, ibus_rsp, ibus_data, dbus_rsp, dbus_data} !== 67'h0)
            $display("[TB] FAIL idle_rsp_ignored: got %h, expected 0", {s_req, ibus_rsp, ibus_data, dbus_rsp, dbus_data});
        else pass_cnt++;
        tick();
        s_rsp = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (s_req !== 1'b0) $display("[TB] FAIL idle_rsp_stay_idle: got %b, expected 0", s_req);
        else pass_cnt++;
    endtask

    task automatic test_drop_req();
        tick();
        ibus_req = 1'b1;
        ibus_addr = 32'h500;
        tick();
        tick();
        ibus_req = 1'b0;
        s_rsp = 1'b1;
        s_data = 32'h77;
        @(negedge clk);
        chk_cnt++;
        if ({s_req, ibus_rsp, ibus_data} !== {1'b1, 1'b0, 32'h0})
            $display("[TB] FAIL drop_req_discard: got %h, expected %h", {s_req, ibus_rsp, ibus_data}, {1'b1, 1'b0, 32'h0});
        else pass_cnt++;
        tick();
        s_rsp = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (s_req !== 1'b0) $display("[TB] FAIL drop_req_close: got %b, expected 0", s_req);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int gnt = 0;
        int streak_m = 0;
        int wait_m = 0;
        int lat = 1;
        bit i_done = 1'b0;
        bit d_done = 1'b0;
        logic [69:0] exp_bus;
        logic [66:0] exp_rsp;
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        s_rsp = 1'b0;
        repeat (2) tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            if (gnt != 0) begin
                if (s_rsp) begin
                    if (gnt == 1) i_done = 1'b1;
                    else d_done = 1'b1;
                    gnt = 0;
                end
            end else if (dbus_req && !(ibus_req && streak_m == MAXS)) begin
                gnt = 2;
                streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
                wait_m = 0;
                lat = $urandom_range(1, 4);
            end else if (ibus_req) begin
                gnt = 1;
                streak_m = 0;
                wait_m = 0;
                lat = $urandom_range(1, 4);
            end else begin
                streak_m = 0;
            end
            #1;
            if (i_done || !ibus_req) begin
                i_done = 1'b0;
                ibus_req = ($urandom_range(0, 3) != 0);
                if (ibus_req) ibus_addr = $urandom;
            end
            if (d_done || !dbus_req) begin
                d_done = 1'b0;
                dbus_req = ($urandom_range(0, 3) != 0);
                if (dbus_req) begin
                    dbus_we = 1'($urandom_range(0, 1));
                    dbus_addr = $urandom;
                    dbus_wdata = $urandom;
                    dbus_be = 4'($urandom_range(0, 15));
                end
            end
            s_data = $urandom;
            if (gnt != 0) begin
                wait_m++;
                s_rsp = (wait_m == lat + 1);
            end else begin
                s_rsp = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            exp_bus = 70'h0;
            if (gnt == 1) exp_bus = {1'b1, 1'b0, ibus_addr, 32'h0, 4'hF};
            else if (gnt == 2) exp_bus = {1'b1, dbus_we, dbus_addr, dbus_wdata, dbus_be};
            exp_rsp = 67'h0;
            if (gnt == 1 && s_rsp) exp_rsp = {1'b1, s_data, 1'b0, 32'h0, 1'b0};
            if (gnt == 2 && s_rsp) exp_rsp = {1'b0, 32'h0, 1'b1, s_data, 1'b0};
            chk_cnt++;
            if ({s_req, s_we, s_addr, s_wdata, s_be} !== exp_bus)
                $display("[TB] FAIL random_bus_c%0d: got %h, expected %h", cyc, {s_req, s_we, s_addr, s_wdata, s_be}, exp_bus);
            else pass_cnt++;
            chk_cnt++;
            if ({ibus_rsp, ibus_data, dbus_rsp, dbus_data, err} !== exp_rsp)
                $display("[TB] FAIL random_rsp_c%0d: got %h, expected %h", cyc, {ibus_rsp, ibus_data, dbus_rsp, dbus_data, err}, exp_rsp);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        s_rsp = 1'b0;
        #2;
        chk_cnt++;
        if (s_req !== 1'b0) $display("[TB] FAIL random_reset: got %b, expected 0", s_req);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        tick();
        ibus_req = 1'b1;
        ibus_addr = 32'h600;
        s_rsp = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            @(negedge clk);
            chk_cnt++;
            if ({s_req, ibus_rsp, err, ibus_data, dbus_rsp} !== {1'b1, (k == 8), (k == 8), 32'h0, 1'b0})
                $display("[TB] FAIL timeout_wait_%0d: got %h, expected %h", k, {s_req, ibus_rsp, err, ibus_data, dbus_rsp},
                         {1'b1, (k == 8), (k == 8), 32'h0, 1'b0});
            else pass_cnt++;
        end
        tick();
        ibus_addr = 32'h700;
        @(negedge clk);
        chk_cnt++;
        if ({s_req, err} !== 2'b00) $display("[TB] FAIL timeout_release: got %b, expected 00", {s_req, err});
        else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({s_req, s_addr} !== {1'b1, 32'h700})
            $display("[TB] FAIL timeout_next_grant: got %h, expected %h", {s_req, s_addr}, {1'b1, 32'h700});
        else pass_cnt++;
        tick();
        s_rsp = 1'b1;
        s_data = 32'h99;
        @(negedge clk);
        chk_cnt++;
        if ({ibus_rsp, ibus_data, err} !== {1'b1, 32'h99, 1'b0})
            $display("[TB] FAIL timeout_next_rsp: got %h, expected %h", {ibus_rsp, ibus_data, err}, {1'b1, 32'h99, 1'b0});
        else pass_cnt++;
        tick();
        s_rsp = 1'b0;
        ibus_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_streak();
        test_reset_mid();
        test_idle_rsp();
        test_drop_req();
        test_random();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000ns, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (I, the ibus side of the fetch stage) and the load/store requester (D, dbus).
- Masters use a req/rsp handshake. Each master holds req, addr and write data stable until it sees rsp.
- The arbiter grants one master at a time and forwards the transaction to the slave. It routes the slave's rsp/rdata back to the granted master only.
- D has fixed priority over I. A streak limit prevents D from starving fetch.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive D grants while I is pending; the next grant then goes to I. Legal range 1..15.
- TIMEOUT, 64: slave response watchdog limit in cycles. Used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ibus_req  in  1  I request
- i_ibus_addr  in  32  I address (read only)
- o_ibus_data  out  32  I read data
- o_ibus_rsp  out  1  I response, 1-cycle pulse
- i_dbus_req  in  1  D request
- i_dbus_we  in  1  D write enable
- i_dbus_addr  in  32  D address
- i_dbus_wdata  in  32  D write data
- i_dbus_be  in  4  D byte enables
- o_dbus_data  out  32  D read data
- o_dbus_rsp  out  1  D response, 1-cycle pulse
- o_s_req  out  1  slave request
- o_s_we  out  1  slave write enable
- o_s_addr  out  32  slave address
- o_s_wdata  out  32  slave write data
- o_s_be  out  4  slave byte enables
- i_s_data  in  32  slave read data
- i_s_rsp  in  1  slave response, valid for one cycle
- o_err  out  1  timeout error pulse; always 0 without the optional feature

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset state: state=IDLE, streak counter=0, timeout counter=0.
- Reset values of outputs: o_s_req=0, o_s_we=0, o_s_addr/o_s_wdata=0, o_s_be=0, both rsp=0, o_err=0, o_ibus_data/o_dbus_data=32'h0.
- States: IDLE, GNT_I, GNT_D.
- IDLE: evaluated at each posedge.
  - i_dbus_req=1 and not (I pending and streak==MAX_D_STREAK): go to GNT_D, streak+=1 (saturating).
  - Else if i_ibus_req=1: go to GNT_I, streak=0.
  - Else stay in IDLE. If i_ibus_req=0, streak=0.
- GNT_x: o_s_req=1. Slave address/data/we/be are combinationally muxed from the granted master. In GNT_I, o_s_we=0 and o_s_be=4'hF.
- Response routing: when i_s_rsp=1, that cycle x_rsp=1 and x_data=i_s_data, combinationally from the slave. Next state is IDLE. The non-granted master sees rsp=0 and data=0.
- Latency: request seen at edge N → o_s_req high from N to the rsp edge. There is a one-cycle IDLE bubble between transactions.
  - Minimum cycle from req to rsp is 2 cycles with a 1-cycle slave.
- A master that drops req while granted is a protocol violation. The arbiter still completes the slave transaction and discards the rsp.
- i_s_rsp in IDLE is ignored; no master rsp is generated.
- Simultaneous I and D requests: D wins unless the streak is saturated at MAX_D_STREAK with I pending. In that case I wins and the streak is cleared.
- Streak counter width is 4 bits and saturates. It is not wrapped.
- Reset mid-transaction: everything returns to IDLE immediately. The outstanding response is dropped; the slave shares the same reset.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering GNT_x and increments each cycle in GNT_x without i_s_rsp.
  - When the counter reaches TIMEOUT-1 with no rsp, the arbiter pulses the granted master's rsp with data 32'h0, pulses o_err, and returns to IDLE.
  - A late i_s_rsp that arrives in IDLE is ignored.
- When undefined: no counter is present, o_err is tied to 0, and GNT_x waits indefinitely.

Test Plan:
- I only, addr 0x100, slave rsp after 1 cycle with 0x00000013 → o_s_addr=0x100, o_s_we=0, o_ibus_rsp pulses once with data 0x13, o_dbus_rsp stays 0.
- I and D requesting continuously with MAX_D_STREAK=4 → grant sequence D,D,D,D,I,D,D,D,D,I. Each master receives only its own rsp.
- D write, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011, slave rsp after 3 cycles → slave fields match; o_s_req high 4 cycles; o_dbus_rsp 1 cycle; no I rsp.
- i_rst_n driven low mid-GNT_D, asynchronously between edges → o_s_req=0 immediately; after release, a pending I is granted first if D is idle.
- i_s_rsp pulsed in IDLE with no requests → no master rsp and the state stays IDLE.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT=8, slave never responds to I → o_ibus_rsp and o_err pulse once, 8 cycles after o_s_req rises, with data 0. The next request is served normally.
